// File: rtl/seq_divider_8by4_if.sv
// Handshake and data bundle for the 8-by-4 sequential divider.
// master drives the request side, slave is the divider itself.
interface seq_divider_8by4_if;
    logic       start;
    logic [7:0] Dividend;
    logic [3:0] Divisor;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, Dividend, Divisor,
        input  Quotient, Remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, Dividend, Divisor,
        output Quotient, Remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8by4.sv
// Unsigned 8-bit by 4-bit restoring divider, one quotient bit per clock, MSB first.
// A zero divisor skips the iterations and reports Quotient=FF, Remainder=Dividend[3:0].
module seq_divider_8by4 (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_8by4_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] dvd_r;
    logic [3:0] dvs_r;
    logic [3:0] pr_r;
    logic [7:0] q_r;
    logic [2:0] cnt_r;
    logic [7:0] quo_r;
    logic [3:0] rem_r;
    logic       dbz_r;
    logic [4:0] step;
    logic       last_iter;

    // Returns {next partial remainder, quotient bit}. When the trial value is
    // at least the divisor the true difference is below 16, so 4-bit
    // subtraction yields the exact result.
    function automatic logic [4:0] restore_step(input logic [3:0] pr,
                                                input logic       nbit,
                                                input logic [3:0] dvs);
        logic [4:0] trial;
        logic       ge;
        trial = {pr, nbit};
        ge    = (trial >= {1'b0, dvs});
        if (ge)
            return {trial[3:0] - dvs, 1'b1};
        else
            return {trial[3:0], 1'b0};
    endfunction

    assign step      = restore_step(pr_r, dvd_r[7], dvs_r);
    assign last_iter = (cnt_r == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.Divisor == 4'd0) ? DONE : CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last_iter)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r <= 8'h00;
            dvs_r <= 4'h0;
            pr_r  <= 4'h0;
            q_r   <= 8'h00;
            cnt_r <= 3'd0;
            quo_r <= 8'h00;
            rem_r <= 4'h0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.Divisor == 4'd0) begin
                            quo_r <= 8'hFF;
                            rem_r <= bus.Dividend[3:0];
                            dbz_r <= 1'b1;
                        end else begin
                            dvd_r <= bus.Dividend;
                            dvs_r <= bus.Divisor;
                            pr_r  <= 4'h0;
                            q_r   <= 8'h00;
                            cnt_r <= 3'd0;
                            dbz_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    // Working registers only; results are published on the last iteration.
                    pr_r  <= step[4:1];
                    dvd_r <= {dvd_r[6:0], 1'b0};
                    q_r   <= {q_r[6:0], step[0]};
                    cnt_r <= cnt_r + 3'd1;
                    if (last_iter) begin
                        quo_r <= {q_r[6:0], step[0]};
                        rem_r <= step[4:1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Quotient    = quo_r;
    assign bus.Remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;

endmodule
